divider_unit: RTL and testbench

Parametrised, multi-cycle integer divider for the execute stage. It is the successor to `divider` and adds the following:
- configurable operand width;
- signed and unsigned modes;
- RISC-V-compliant handling of divide-by-zero and signed overflow;
- an explicit `busy`/`done` handshake and synchronous reset.

It produces one quotient bit per cycle using restoring division on operand magnitudes, followed by a sign-fix cycle.

---
 rtl/divider_unit.sv | 148 ++++++++++++++
 tb/tb_divider_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/divider_unit.sv
// divider_unit: multi-cycle restoring integer divider, signed/unsigned,
// one quotient bit per cycle followed by a sign-fix cycle.
// Optional build macro: DIVIDER_UNIT_FAST_SPECIAL_EN -- when defined,
// divide-by-zero and signed overflow skip the iteration phase.
module divider_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quo;        // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] rem;        // partial remainder between iterations
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] a_raw;
  logic             neg_q;
  logic             neg_r;
  logic             zero_case;
  logic             ovf_case;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             in_zero;
  logic             in_ovf;

  logic [WIDTH:0]   partial;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Operand decode at the sampling point: signs, magnitudes, special cases
  always_comb begin
    a_neg   = is_signed & a[WIDTH-1];
    b_neg   = is_signed & b[WIDTH-1];
    abs_a   = a_neg ? -a : a;
    abs_b   = b_neg ? -b : b;
    in_zero = (b == '0);
    in_ovf  = is_signed && (a == MOST_NEG) && (b == '1);
  end

  // One restoring step on a WIDTH+1 bit partial remainder, plus sign fix-up
  always_comb begin
    partial  = {rem, quo[WIDTH-1]};
    fits     = (partial >= {1'b0, dvsr});
    rem_next = fits ? WIDTH'(partial - {1'b0, dvsr}) : partial[WIDTH-1:0];
    q_fix    = neg_q ? -quo : quo;
    r_fix    = neg_r ? -rem : rem;
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      quo         <= '0;
      rem         <= '0;
      dvsr        <= '0;
      a_raw       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero_case   <= 1'b0;
      ovf_case    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            count     <= CW'(WIDTH);
            quo       <= abs_a;
            rem       <= '0;
            dvsr      <= abs_b;
            a_raw     <= a;
            neg_q     <= a_neg ^ b_neg;
            neg_r     <= a_neg;
            zero_case <= in_zero;
            ovf_case  <= in_ovf;
`ifdef DIVIDER_UNIT_FAST_SPECIAL_EN
            // Special cases need no iterations: FIX alone produces them
            if (in_zero || in_ovf)
              state <= FIX;
            else
              state <= RUN;
`else
            state <= RUN;
`endif
          end
        end
        RUN: begin
          busy  <= 1'b1;
          rem   <= rem_next;
          quo   <= {quo[WIDTH-2:0], fits};
          count <= count - 1'b1;
          if (count == CW'(1))
            state <= FIX;
        end
        FIX: begin
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= zero_case;
          state       <= IDLE;
          if (zero_case) begin
            result    <= '1;
            remainder <= a_raw;
          end else if (ovf_case) begin
            result    <= a_raw;
            remainder <= '0;
          end else begin
            result    <= q_fix;
            remainder <= r_fix;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// Directed self-checking bench for divider_unit (WIDTH=32).
// Expected latency of special cases follows DIVIDER_UNIT_FAST_SPECIAL_EN.
module tb_divider_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;
`ifdef DIVIDER_UNIT_FAST_SPECIAL_EN
  localparam int SPL = 1;
`else
  localparam int SPL = W + 1;
`endif

  logic         clock;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  divider_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request so it is sampled at the next rising edge (edge 0)
  task automatic launch(input logic [31:0] va, input logic [31:0] vb, input logic sgn);
    a = va; b = vb; is_signed = sgn; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; is_signed = 1'b1;
  endtask

  // Launch, follow edges 1.. until done (bounded), then check everything
  task automatic run(input string tag, input logic [31:0] va, input logic [31:0] vb,
                     input logic sgn, input int lat, input logic [31:0] eq,
                     input logic [31:0] er, input logic edz, input int poke_at);
    int done_edge;
    int busy_bad;
    done_edge = -1;
    busy_bad  = 0;
    launch(va, vb, sgn);
    if (busy !== 1'b0) busy_bad++;
    for (int k = 1; k <= 45 && done_edge < 0; k++) begin
      if (k == poke_at) begin
        a = 32'd9; b = 32'd3; is_signed = 1'b0; start = 1'b1;
      end
      @(posedge clock); #1;
      if (k == poke_at) start = 1'b0;
      if (done === 1'b1) done_edge = k;
      if (busy !== ((k >= 1 && k < lat) ? 1'b1 : 1'b0)) busy_bad++;
    end
    check({tag, " done_edge"}, done_edge, lat);
    check({tag, " busy_pattern_errs"}, busy_bad, 0);
    check({tag, " result"}, result, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edz});
  endtask

  initial begin
    int dones;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset busy", {31'd0, busy}, 0);
    check("reset done", {31'd0, done}, 0);
    check("reset result", result, 0);
    check("reset remainder", remainder, 0);
    check("reset div_by_zero", {31'd0, div_by_zero}, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    run("u 1000/20", 32'd1000, 32'd20, 1'b0, LAT, 32'd50, 32'd0, 1'b0, 0);
    @(posedge clock); #1;
    check("done single pulse", {31'd0, done}, 0);
    check("result held", result, 32'd50);

    run("s -1000/20", 32'hFFFFFC18, 32'd20, 1'b1, LAT, 32'hFFFFFFCE, 32'd0, 1'b0, 0);
    run("s -7/2", 32'hFFFFFFF9, 32'd2, 1'b1, LAT, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 0);
    run("s 7/-2", 32'd7, 32'hFFFFFFFE, 1'b1, LAT, 32'hFFFFFFFD, 32'd1, 1'b0, 0);
    run("u FFFFFFF9/2", 32'hFFFFFFF9, 32'd2, 1'b0, LAT, 32'h7FFFFFFC, 32'd1, 1'b0, 0);
    run("s 5/0", 32'd5, 32'd0, 1'b1, SPL, 32'hFFFFFFFF, 32'd5, 1'b1, 0);
    run("u 5/0", 32'd5, 32'd0, 1'b0, SPL, 32'hFFFFFFFF, 32'd5, 1'b1, 0);
    run("s ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, SPL, 32'h80000000, 32'd0, 1'b0, 0);
    run("u 80000000/FFFFFFFF", 32'h80000000, 32'hFFFFFFFF, 1'b0, LAT, 32'd0, 32'h80000000, 1'b0, 0);

    // Start during busy is ignored; next start right after done is accepted
    run("u 100/7 poked", 32'd100, 32'd7, 1'b0, LAT, 32'd14, 32'd2, 1'b0, 5);
    run("u 9/3 back2back", 32'd9, 32'd3, 1'b0, LAT, 32'd3, 32'd0, 1'b0, 0);

    // Mid-operation reset after non-zero outputs are on display
    run("u 5/0 pre-reset", 32'd5, 32'd0, 1'b0, SPL, 32'hFFFFFFFF, 32'd5, 1'b1, 0);
    launch(32'd1000, 32'd20, 1'b0);
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort busy", {31'd0, busy}, 0);
    check("abort done", {31'd0, done}, 0);
    check("abort result", result, 0);
    check("abort remainder", remainder, 0);
    check("abort div_by_zero", {31'd0, div_by_zero}, 0);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    check("abort no done/busy", dones, 0);
    run("u 81/9 after reset", 32'd81, 32'd9, 1'b0, LAT, 32'd9, 32'd0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
